// File: rtl/stream_demux_pkg.sv
// Shared types and route constants for the 1:2 packet-aware stream demultiplexer.
package stream_demux_pkg;

  typedef enum logic {IDLE, PKT} demux_state_e;

  localparam logic OUT_0 = 1'b0;
  localparam logic OUT_1 = 1'b1;

endpackage

// File: rtl/stream_demux_if.sv
// Bus bundle for stream_demux_1_2: one input stream and two output streams.
interface stream_demux_if #(
  parameter int DATA_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sel;
  logic              in_last;

  logic              out0_valid;
  logic              out0_ready;
  logic [DATA_W-1:0] out0_data;
  logic              out0_last;

  logic              out1_valid;
  logic              out1_ready;
  logic [DATA_W-1:0] out1_data;
  logic              out1_last;

  // Demux side: consumes the input stream, produces both output streams.
  modport slave (
    input  in_valid, in_data, in_sel, in_last, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out0_last, out1_valid, out1_data, out1_last
  );

  // Environment side: producer and both consumers.
  modport master (
    output in_valid, in_data, in_sel, in_last, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out0_last, out1_valid, out1_data, out1_last
  );

endinterface

// File: rtl/stream_out_slot.sv
// One-entry registered output slot: a load takes priority over a drain, so a
// simultaneous load and drain replaces the held beat and keeps valid high.
module stream_out_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

// File: rtl/stream_demux_1_2.sv
// 1:2 packet-aware stream demux: route sampled on the first beat, held until in_last.
// Optional per-output beat counters cnt0/cnt1 when STREAM_DEMUX_STATS_EN is defined.
module stream_demux_1_2
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8
`ifdef STREAM_DEMUX_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  stream_demux_if.slave      bus
`ifdef STREAM_DEMUX_STATS_EN
  , output logic [CNT_W-1:0] cnt0
  , output logic [CNT_W-1:0] cnt1
`endif
);

  demux_state_e r_state;
  demux_state_e w_state_nxt;
  logic         r_lock_sel;
  logic         w_lock_nxt;
  logic         w_route;
  logic         w_in_ready;
  logic         w_accept;
  logic         w_load0;
  logic         w_load1;
  logic         w_out0_valid;
  logic         w_out1_valid;

  // Mid-packet the locked route wins; in_sel only matters on a first beat.
  assign w_route    = (r_state == PKT) ? r_lock_sel : bus.in_sel;
  assign w_in_ready = (w_route == OUT_0) ? (!w_out0_valid || bus.out0_ready)
                                         : (!w_out1_valid || bus.out1_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_load0    = w_accept && (w_route == OUT_0);
  assign w_load1    = w_accept && (w_route == OUT_1);
  assign bus.in_ready = w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_lock_sel <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_sel <= w_lock_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_sel;
    if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (!bus.in_last) begin
            w_state_nxt = PKT;
            w_lock_nxt  = bus.in_sel;
          end
        end
        PKT: begin
          if (bus.in_last) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  stream_out_slot #(.DATA_W(DATA_W)) u_slot0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load0),
    .i_data  (bus.in_data),
    .i_last  (bus.in_last),
    .i_ready (bus.out0_ready),
    .o_valid (w_out0_valid),
    .o_data  (bus.out0_data),
    .o_last  (bus.out0_last)
  );

  stream_out_slot #(.DATA_W(DATA_W)) u_slot1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load1),
    .i_data  (bus.in_data),
    .i_last  (bus.in_last),
    .i_ready (bus.out1_ready),
    .o_valid (w_out1_valid),
    .o_data  (bus.out1_data),
    .o_last  (bus.out1_last)
  );

  assign bus.out0_valid = w_out0_valid;
  assign bus.out1_valid = w_out1_valid;

`ifdef STREAM_DEMUX_STATS_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Counters wrap silently at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_out0_valid && bus.out0_ready) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_out1_valid && bus.out1_ready) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_stream_demux_1_2.sv
// Directed self-checking bench for stream_demux_1_2 (stats checks need STREAM_DEMUX_STATS_EN).
module tb_stream_demux_1_2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  stream_demux_if #(.DATA_W(8)) bus ();

`ifdef STREAM_DEMUX_STATS_EN
  logic [2:0] cnt0;
  logic [2:0] cnt1;
`endif

  stream_demux_1_2 #(
    .DATA_W(8)
`ifdef STREAM_DEMUX_STATS_EN
    , .CNT_W(3)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef STREAM_DEMUX_STATS_EN
    , .cnt0 (cnt0)
    , .cnt1 (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic l);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_sel   = s;
    bus.in_last  = l;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // 1. reset with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      bus.out0_ready = 1'($urandom);
      bus.out1_ready = 1'($urandom);
      #1;
      check_eq("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
      check_eq("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
      check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    end
    check_eq("rst_out0_data", 32'(bus.out0_data), 32'h0);
    check_eq("rst_out1_last", 32'(bus.out1_last), 32'h0);
`ifdef STREAM_DEMUX_STATS_EN
    check_eq("rst_cnt0", 32'(cnt0), 32'd0);
    check_eq("rst_cnt1", 32'(cnt1), 32'd0);
`endif
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 2. alternating single-beat routing
    drive(1'b1, 8'hA5, 1'b0, 1'b1);
    #1;
    check_eq("alt_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check_eq("alt_out0_valid", 32'(bus.out0_valid), 32'd1);
    check_eq("alt_out0_data", 32'(bus.out0_data), 32'hA5);
    check_eq("alt_out0_last", 32'(bus.out0_last), 32'd1);
    check_eq("alt_out1_idle", 32'(bus.out1_valid), 32'd0);
    drive(1'b1, 8'h3C, 1'b1, 1'b1);
    tick();
    check_eq("alt_out1_valid", 32'(bus.out1_valid), 32'd1);
    check_eq("alt_out1_data", 32'(bus.out1_data), 32'h3C);
    check_eq("alt_out0_drained", 32'(bus.out0_valid), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // 3. route lock across a 3-beat packet
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    check_eq("lock_b1_data", 32'(bus.out0_data), 32'h11);
    check_eq("lock_b1_last", 32'(bus.out0_last), 32'd0);
    drive(1'b1, 8'h22, 1'b1, 1'b0);
    tick();
    check_eq("lock_b2_valid", 32'(bus.out0_valid), 32'd1);
    check_eq("lock_b2_data", 32'(bus.out0_data), 32'h22);
    check_eq("lock_b2_out1", 32'(bus.out1_valid), 32'd0);
    drive(1'b1, 8'h33, 1'b1, 1'b1);
    tick();
    check_eq("lock_b3_data", 32'(bus.out0_data), 32'h33);
    check_eq("lock_b3_last", 32'(bus.out0_last), 32'd1);
    check_eq("lock_b3_out1", 32'(bus.out1_valid), 32'd0);
    drive(1'b1, 8'h44, 1'b1, 1'b1);
    tick();
    check_eq("lock_next_valid", 32'(bus.out1_valid), 32'd1);
    check_eq("lock_next_data", 32'(bus.out1_data), 32'h44);
    check_eq("lock_next_out0", 32'(bus.out0_valid), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // 4. back-pressure on out0, out1 keeps flowing
    bus.out0_ready = 1'b0;
    drive(1'b1, 8'h01, 1'b0, 1'b1);
    tick();
    check_eq("bp_hold_valid", 32'(bus.out0_valid), 32'd1);
    check_eq("bp_hold_data", 32'(bus.out0_data), 32'h01);
    drive(1'b1, 8'h02, 1'b0, 1'b1);
    #1;
    check_eq("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    tick();
    check_eq("bp_stable_data", 32'(bus.out0_data), 32'h01);
    drive(1'b1, 8'h55, 1'b1, 1'b1);
    #1;
    check_eq("bp_other_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check_eq("bp_other_data", 32'(bus.out1_data), 32'h55);
    check_eq("bp_other_valid", 32'(bus.out1_valid), 32'd1);
    check_eq("bp_still_01", 32'(bus.out0_data), 32'h01);
    drive(1'b1, 8'h02, 1'b0, 1'b1);
    #1;
    check_eq("bp_pending_ready", 32'(bus.in_ready), 32'd0);
    bus.out0_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check_eq("bp_swap_valid", 32'(bus.out0_valid), 32'd1);
    check_eq("bp_swap_data", 32'(bus.out0_data), 32'h02);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check_eq("bp_empty", 32'(bus.out0_valid), 32'd0);

    // 5. reset in the middle of a packet
    bus.out0_ready = 1'b0;
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    tick();
    check_eq("mid_b1_valid", 32'(bus.out0_valid), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_async_out0", 32'(bus.out0_valid), 32'd0);
    check_eq("mid_async_out1", 32'(bus.out1_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(1'b1, 8'h88, 1'b1, 1'b1);
    tick();
    check_eq("mid_after_valid", 32'(bus.out1_valid), 32'd1);
    check_eq("mid_after_data", 32'(bus.out1_data), 32'h88);
    check_eq("mid_after_out0", 32'(bus.out0_valid), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    bus.out0_ready = 1'b1;
    tick();

`ifdef STREAM_DEMUX_STATS_EN
    // 6. beat counters with wrap at 2^3
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b1);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'(i + 16), 1'b1, 1'b1);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    check_eq("stats_cnt0", 32'(cnt0), 32'd5);
    check_eq("stats_cnt1", 32'(cnt1), 32'd2);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(i + 32), 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    check_eq("stats_wrap_cnt0", 32'(cnt0), 32'd1);
    check_eq("stats_hold_cnt1", 32'(cnt1), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
